// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
//
// Data-memory request/acknowledge bus between the M stage and data memory.
//
// Signals:
//   DataReq   - access request (stage -> memory)
//   DataWe    - 1 = store, 0 = load (stage -> memory)
//   DataAdr   - word address (stage -> memory)
//   DataWdata - store data (stage -> memory)
//   DataAck   - memory accepts the access; load data valid the same cycle
//   DataRdata - load data (memory -> stage)
//
// Modports: master = pipeline stage side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_stage_if;
    logic        DataReq;
    logic        DataWe;
    logic [31:0] DataAdr;
    logic [31:0] DataWdata;
    logic        DataAck;
    logic [31:0] DataRdata;

    modport master (
        output DataReq, DataWe, DataAdr, DataWdata,
        input  DataAck, DataRdata
    );

    modport slave (
        input  DataReq, DataWe, DataAdr, DataWdata,
        output DataAck, DataRdata
    );
endinterface : mem_stage_if

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the pipelined ARM core. Holds the E/M and M/W
// pipeline registers and drives data memory over a req/ack handshake that
// tolerates any number of wait states. While an access is outstanding the
// front of the pipe is stalled and W receives bubbles.
//
// Ports:
//   clk, reset         - clock; asynchronous active-low reset
//   RegWriteE, MemtoRegE, MemWriteE, RdE, ALUResultE, WriteDataE
//                      - E-stage inputs (controls already condition-qualified)
//   dmem               - data-memory bus (mem_stage_if.master)
//   StallM             - hold F/D/E and do not advance E into M
//   RegWriteM, RdM, ALUResultM
//                      - M-stage forwarding / hazard sources
//   RegWriteW, MemtoRegW, RdW, ALUOutW, ReadDataW
//                      - Writeback inputs
//   MemFault           - sticky access-timeout flag
//
// Build option:
//   MEM_TIMEOUT_EN - when defined, a watchdog aborts an access that has sat in
//                    WAIT for TIMEOUT cycles, retires it to W without a
//                    register write and sets MemFault. When undefined the
//                    stage waits indefinitely and MemFault is tied 0.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWriteE,
    input  logic               MemtoRegE,
    input  logic               MemWriteE,
    input  logic [3:0]         RdE,
    input  logic [31:0]        ALUResultE,
    input  logic [31:0]        WriteDataE,
    mem_stage_if.master        dmem,
    output logic               StallM,
    output logic               RegWriteM,
    output logic [3:0]         RdM,
    output logic [31:0]        ALUResultM,
    output logic               RegWriteW,
    output logic               MemtoRegW,
    output logic [3:0]         RdW,
    output logic [31:0]        ALUOutW,
    output logic [31:0]        ReadDataW,
    output logic               MemFault
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [3:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] write_data;
    } m_reg_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [3:0]  rd;
        logic [31:0] alu_out;
        logic [31:0] read_data;
    } w_reg_t;

    state_e state_q, state_d;
    m_reg_t m_q, m_d;
    w_reg_t w_q, w_d;

    logic memop;
    logic data_req;
    logic stall_m;
    logic abort;

    assign memop = m_q.mem_to_reg | m_q.mem_write;

    // Both FSM states issue the request; WAIT only marks that the access has
    // already been stalled at least once.
    assign data_req = memop & ((state_q == S_IDLE) | (state_q == S_WAIT));
    assign stall_m  = data_req & ~dmem.DataAck & ~abort;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_fault_q, mem_fault_d;

    // Abort on the TIMEOUT-th WAIT cycle; a late ack in that same cycle still
    // completes normally.
    assign abort = (state_q == S_WAIT) & ~dmem.DataAck &
                   (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        mem_fault_d = mem_fault_q | abort;
        // Held at zero in IDLE so the count starts from 0 on entry to WAIT.
        if (state_q == S_IDLE)
            wait_cnt_d = '0;
        else if (wait_cnt_q != '1)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign MemFault = mem_fault_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT);
    assign abort          = 1'b0;
    assign MemFault       = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        w_d     = w_q;

        unique case (state_q)
            S_IDLE: if (memop && !dmem.DataAck) state_d = S_WAIT;
            S_WAIT: if (dmem.DataAck || abort)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (!stall_m) begin
            m_d.reg_write  = RegWriteE;
            m_d.mem_to_reg = MemtoRegE;
            m_d.mem_write  = MemWriteE;
            m_d.rd         = RdE;
            m_d.alu_result = ALUResultE;
            m_d.write_data = WriteDataE;

            // An aborted access retires without writing the register file.
            w_d.reg_write  = m_q.reg_write & ~abort;
            w_d.mem_to_reg = m_q.mem_to_reg & ~abort;
            w_d.rd         = m_q.rd;
            w_d.alu_out    = m_q.alu_result;
            if (m_q.mem_to_reg && dmem.DataAck && !abort)
                w_d.read_data = dmem.DataRdata;
        end else begin
            // Bubble into W; the remaining W fields keep their last values.
            w_d.reg_write  = 1'b0;
            w_d.mem_to_reg = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values computed before this edge.
    // NOTE: reset is asynchronous; pulling it low mid-access clears the M
    // register and with it DataReq, without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            w_q     <= w_d;
        end
    end

    assign dmem.DataReq   = data_req;
    assign dmem.DataWe    = m_q.mem_write;
    assign dmem.DataAdr   = m_q.alu_result;
    assign dmem.DataWdata = m_q.write_data;

    assign StallM     = stall_m;
    assign RegWriteM  = m_q.reg_write;
    assign RdM        = m_q.rd;
    assign ALUResultM = m_q.alu_result;
    assign RegWriteW  = w_q.reg_write;
    assign MemtoRegW  = w_q.mem_to_reg;
    assign RdW        = w_q.rd;
    assign ALUOutW    = w_q.alu_out;
    assign ReadDataW  = w_q.read_data;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage. Inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns later, well clear of the active edge. The memory
// side (DataAck/DataRdata) is driven directly by each scenario task.
// ---------------------------------------------------------------------------
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 16;
`endif

    logic        clk;
    logic        reset;
    logic        RegWriteE, MemtoRegE, MemWriteE;
    logic [3:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE;
    logic        StallM, RegWriteM, RegWriteW, MemtoRegW, MemFault;
    logic [3:0]  RdM, RdW;
    logic [31:0] ALUResultM, ALUOutW, ReadDataW;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if dmem();

    mem_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteE  (RegWriteE),
        .MemtoRegE  (MemtoRegE),
        .MemWriteE  (MemWriteE),
        .RdE        (RdE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .dmem       (dmem),
        .StallM     (StallM),
        .RegWriteM  (RegWriteM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .RdW        (RdW),
        .ALUOutW    (ALUOutW),
        .ReadDataW  (ReadDataW),
        .MemFault   (MemFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic rw, input logic mtr, input logic mw,
                           input logic [3:0] rd, input logic [31:0] alu,
                           input logic [31:0] wd);
        RegWriteE  = rw;
        MemtoRegE  = mtr;
        MemWriteE  = mw;
        RdE        = rd;
        ALUResultE = alu;
        WriteDataE = wd;
    endtask

    task automatic drive_nop();
        drive_e(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic drive_mem(input logic ack, input logic [31:0] rdata);
        dmem.DataAck   = ack;
        dmem.DataRdata = rdata;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        drive_nop();
        drive_mem(1'b0, 32'd0);
        #12;
        n_checks++;
        if ({dmem.DataReq, StallM, RegWriteM, RegWriteW, MemtoRegW, MemFault} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {dmem.DataReq, StallM, RegWriteM, RegWriteW, MemtoRegW, MemFault});
        end
        n_checks++;
        if ({RdM, RdW, ALUResultM, ALUOutW, ReadDataW} !== 104'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {RdM, RdW, ALUResultM, ALUOutW, ReadDataW});
        end
        reset = 1'b1;
        step();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_zero_wait_load();
        drive_e(1'b1, 1'b1, 1'b0, 4'd3, 32'h100, 32'd0);
        step();
        drive_nop();
        drive_mem(1'b1, 32'hDEADBEEF);
        #1;
        n_checks++;
        if ({dmem.DataReq, dmem.DataWe, StallM, dmem.DataAdr} !== {3'b100, 32'h100}) begin
            n_fail++;
            $display("FAIL zw_load_req: got req/we/stall=%b adr=%h expected 100 adr=00000100",
                     {dmem.DataReq, dmem.DataWe, StallM}, dmem.DataAdr);
        end
        step();
        drive_mem(1'b0, 32'd0);
        #1;
        n_checks++;
        if ({ReadDataW, RdW, RegWriteW, MemtoRegW} !== {32'hDEADBEEF, 4'd3, 2'b11}) begin
            n_fail++;
            $display("FAIL zw_load_w: got rdata=%h rd=%0d rw=%b mtr=%b expected deadbeef 3 1 1",
                     ReadDataW, RdW, RegWriteW, MemtoRegW);
        end
        step();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_store_wait();
        int stall_cycles = 0;
        int unsteady     = 0;
        drive_e(1'b0, 1'b0, 1'b1, 4'd0, 32'h40, 32'h12345678);
        step();
        drive_nop();
        for (int i = 0; i < 4; i++) begin
            drive_mem(i == 3, 32'h0BAD0BAD);
            #1;
            if (StallM) stall_cycles++;
            if ({dmem.DataReq, dmem.DataWe, dmem.DataAdr, dmem.DataWdata, RegWriteW}
                !== {2'b11, 32'h40, 32'h12345678, 1'b0})
                unsteady++;
            step();
        end
        drive_mem(1'b0, 32'd0);
        #1;
        n_checks++;
        if (stall_cycles != 3) begin
            n_fail++;
            $display("FAIL store_stall_cycles: got %0d expected 3", stall_cycles);
        end
        n_checks++;
        if (unsteady != 0) begin
            n_fail++;
            $display("FAIL store_bus_steady: got %0d unsteady cycles expected 0", unsteady);
        end
        n_checks++;
        if ({RegWriteW, MemtoRegW, ReadDataW, ALUOutW, dmem.DataReq}
            !== {2'b00, 32'hDEADBEEF, 32'h40, 1'b0}) begin
            n_fail++;
            $display("FAIL store_w: got rw=%b mtr=%b rdata=%h alu=%h req=%b expected 0 0 deadbeef 00000040 0",
                     RegWriteW, MemtoRegW, ReadDataW, ALUOutW, dmem.DataReq);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_alu_behind_load();
        int bad = 0;
        drive_e(1'b1, 1'b1, 1'b0, 4'd2, 32'h200, 32'd0);
        step();
        drive_e(1'b1, 1'b0, 1'b0, 4'd5, 32'd7, 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive_mem(1'b0, 32'd0);
            #1;
            if ({StallM, RdM, ALUResultM} !== {1'b1, 4'd2, 32'h200}) bad++;
            if (i > 0 && RegWriteW !== 1'b0) bad++;
            step();
        end
        #1;
        n_checks++;
        if (bad != 0 || RegWriteW !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_stall_hold: got %0d bad cycles rw_w=%b expected 0 0", bad, RegWriteW);
        end
        drive_mem(1'b1, 32'hCAFEF00D);
        #1;
        n_checks++;
        if (StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_ack_stall: got %b expected 0", StallM);
        end
        step();
        drive_nop();
        drive_mem(1'b1, 32'h00000BAD);  // ack with no request must be ignored
        #1;
        n_checks++;
        if ({RdM, ALUResultM, RegWriteM} !== {4'd5, 32'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL alu_enters_m: got rd=%0d res=%h rw=%b expected 5 00000007 1",
                     RdM, ALUResultM, RegWriteM);
        end
        n_checks++;
        if ({RdW, ReadDataW, RegWriteW, MemtoRegW, dmem.DataReq, StallM}
            !== {4'd2, 32'hCAFEF00D, 4'b1100}) begin
            n_fail++;
            $display("FAIL alu_load_w: got rd=%0d rdata=%h rw=%b mtr=%b req=%b stall=%b expected 2 cafef00d 1 1 0 0",
                     RdW, ReadDataW, RegWriteW, MemtoRegW, dmem.DataReq, StallM);
        end
        step();
        drive_mem(1'b0, 32'd0);
        #1;
        n_checks++;
        if ({RdW, ALUOutW, ReadDataW, RegWriteW, MemtoRegW}
            !== {4'd5, 32'd7, 32'hCAFEF00D, 2'b10}) begin
            n_fail++;
            $display("FAIL alu_w: got rd=%0d alu=%h rdata=%h rw=%b mtr=%b expected 5 00000007 cafef00d 1 0",
                     RdW, ALUOutW, ReadDataW, RegWriteW, MemtoRegW);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        drive_e(1'b1, 1'b1, 1'b0, 4'd6, 32'h0, 32'd0);
        step();
        drive_e(1'b1, 1'b1, 1'b0, 4'd7, 32'h4, 32'd0);
        drive_mem(1'b1, 32'h11111111);
        #1;
        n_checks++;
        if ({dmem.DataReq, StallM, dmem.DataAdr} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL b2b_first_req: got req=%b stall=%b adr=%h expected 1 0 00000000",
                     dmem.DataReq, StallM, dmem.DataAdr);
        end
        step();
        drive_nop();
        drive_mem(1'b1, 32'h22222222);
        #1;
        n_checks++;
        if ({dmem.DataReq, StallM, dmem.DataAdr, RdW, ReadDataW, RegWriteW}
            !== {2'b10, 32'h4, 4'd6, 32'h11111111, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second_req: got req=%b stall=%b adr=%h rd_w=%0d rdata=%h rw=%b expected 1 0 00000004 6 11111111 1",
                     dmem.DataReq, StallM, dmem.DataAdr, RdW, ReadDataW, RegWriteW);
        end
        step();
        drive_mem(1'b0, 32'd0);
        #1;
        n_checks++;
        if ({dmem.DataReq, RdW, ReadDataW, RegWriteW} !== {1'b0, 4'd7, 32'h22222222, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second_w: got req=%b rd=%0d rdata=%h rw=%b expected 0 7 22222222 1",
                     dmem.DataReq, RdW, ReadDataW, RegWriteW);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        int stall_cycles = 0;
        drive_e(1'b1, 1'b1, 1'b0, 4'd10, 32'h500, 32'd0);
        step();
        drive_nop();
        drive_mem(1'b0, 32'd0);
        #1;
        while (StallM && stall_cycles < 12) begin
            stall_cycles++;
            step();
            #1;
        end
        n_checks++;
        if (stall_cycles != 4 || dmem.DataReq !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_stall: got %0d cycles req=%b expected 4 1", stall_cycles, dmem.DataReq);
        end
        step();
        #1;
        n_checks++;
        if ({RegWriteW, MemtoRegW, MemFault, dmem.DataReq, RdW} !== {4'b0010, 4'd10}) begin
            n_fail++;
            $display("FAIL timeout_retire: got rw=%b mtr=%b fault=%b req=%b rd=%0d expected 0 0 1 0 10",
                     RegWriteW, MemtoRegW, MemFault, dmem.DataReq, RdW);
        end
        drive_e(1'b1, 1'b1, 1'b0, 4'd11, 32'h504, 32'd0);
        step();
        drive_nop();
        drive_mem(1'b1, 32'h33333333);
        step();
        drive_mem(1'b0, 32'd0);
        #1;
        n_checks++;
        if ({ReadDataW, RegWriteW, MemFault} !== {32'h33333333, 2'b11}) begin
            n_fail++;
            $display("FAIL timeout_sticky: got rdata=%h rw=%b fault=%b expected 33333333 1 1",
                     ReadDataW, RegWriteW, MemFault);
        end
`else
        int bad = 0;
        drive_e(1'b1, 1'b1, 1'b0, 4'd10, 32'h500, 32'd0);
        step();
        drive_nop();
        drive_mem(1'b0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ({StallM, dmem.DataReq, MemFault, RegWriteW} !== 4'b1100) bad++;
            step();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_watchdog_wait: got %0d bad cycles expected 0", bad);
        end
        drive_mem(1'b1, 32'h44444444);
        step();
        drive_mem(1'b0, 32'd0);
        #1;
        n_checks++;
        if ({ReadDataW, RdW, RegWriteW, MemFault} !== {32'h44444444, 4'd10, 2'b10}) begin
            n_fail++;
            $display("FAIL no_watchdog_done: got rdata=%h rd=%0d rw=%b fault=%b expected 44444444 10 1 0",
                     ReadDataW, RdW, RegWriteW, MemFault);
        end
`endif
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_wait();
        drive_e(1'b1, 1'b1, 1'b0, 4'd9, 32'h300, 32'd0);
        step();
        drive_nop();
        drive_mem(1'b0, 32'd0);
        step();
        #1;
        n_checks++;
        if ({dmem.DataReq, StallM, RegWriteM} !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_wait_pending: got req/stall/rw_m=%b expected 111",
                     {dmem.DataReq, StallM, RegWriteM});
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({dmem.DataReq, StallM, RegWriteM, RegWriteW, MemFault} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_async: got req/stall/rw_m/rw_w/fault=%b expected 00000",
                     {dmem.DataReq, StallM, RegWriteM, RegWriteW, MemFault});
        end
        step();
        #2;
        reset = 1'b1;
        step();
        #1;
        n_checks++;
        if ({dmem.DataReq, StallM, RdW, ReadDataW} !== {2'b00, 4'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_release: got req=%b stall=%b rd_w=%0d rdata=%h expected 0 0 0 00000000",
                     dmem.DataReq, StallM, RdW, ReadDataW);
        end
        // A fresh zero-wait load must complete without a stall from IDLE.
        drive_e(1'b1, 1'b1, 1'b0, 4'd4, 32'h600, 32'd0);
        step();
        drive_nop();
        drive_mem(1'b1, 32'h55555555);
        #1;
        n_checks++;
        if ({dmem.DataReq, StallM, dmem.DataAdr} !== {2'b10, 32'h600}) begin
            n_fail++;
            $display("FAIL rst_after_load: got req=%b stall=%b adr=%h expected 1 0 00000600",
                     dmem.DataReq, StallM, dmem.DataAdr);
        end
        step();
        drive_mem(1'b0, 32'd0);
        #1;
        n_checks++;
        if ({ReadDataW, RdW, RegWriteW} !== {32'h55555555, 4'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_after_w: got rdata=%h rd=%0d rw=%b expected 55555555 4 1",
                     ReadDataW, RdW, RegWriteW);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_alu_behind_load();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_stage

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined ARM core, between the Execute stage and Writeback. It holds the E/M and M/W pipeline registers and drives data memory over a req/ack handshake that tolerates variable wait states. It stalls the front of the pipe while an access is outstanding and exports the M-stage result, destination and write enable to the forwarding/hazard logic.

## Interface
- `TIMEOUT`, 16: wait-state limit before a pending access is aborted; used only when the watchdog is compiled in.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `RegWriteE`, `MemtoRegE`, `MemWriteE` in 1 each: E-stage controls, already condition-qualified.
- `RdE` in 4: E-stage destination register.
- `ALUResultE` in 32: address for memory ops, result for others.
- `WriteDataE` in 32: store data.
- `DataAck` in 1: memory accepts the access; for loads, `DataRdata` is valid in the same cycle.
- `DataRdata` in 32: load data.
- `DataReq` out 1: access request.
- `DataWe` out 1: 1 = store, 0 = load.
- `DataAdr` out 32: word address, equal to `ALUResultM`.
- `DataWdata` out 32: store data.
- `StallM` out 1: hold the F/D/E stages and do not advance E into M.
- `RegWriteM` out 1, `RdM` out 4, `ALUResultM` out 32: forwarding and hazard sources.
- `RegWriteW`, `MemtoRegW` out 1 each; `RdW` out 4; `ALUOutW`, `ReadDataW` out 32: Writeback inputs.
- `MemFault` out 1: sticky; an access timed out. Driven only when `MEM_TIMEOUT_EN` is defined, otherwise tied 0.

## Operation
- The M register holds `RegWriteM`, `MemtoRegM`, `MemWriteM`, `RdM`, `ALUResultM` and `WriteDataM`.
- A memory op is present when `MemtoRegM` or `MemWriteM` is set.
- `DataReq = memop & (state==IDLE | state==WAIT)`. This is combinational from the M register and state.
- `DataWe = MemWriteM`, `DataAdr = ALUResultM`, `DataWdata = WriteDataM`.
- `StallM = DataReq & ~DataAck & ~abort`. `abort` exists only under `MEM_TIMEOUT_EN`.
- Edge with `StallM = 0`:
  - M captures the E inputs.
  - W captures M: `RegWriteW`, `MemtoRegW`, `RdW`, and `ALUOutW <= ALUResultM`.
  - `ReadDataW <= DataRdata` only for a completing load; otherwise `ReadDataW` holds its value.
- Edge with `StallM = 1`:
  - M holds its contents.
  - W takes a bubble: `RegWriteW <= 0`, `MemtoRegW <= 0`. Other W fields hold.
- FSM, 2 states:
  - `IDLE`: no access pending beyond the current cycle. Memop and no ack go to `WAIT`. An ack, or no memop, stays in `IDLE`.
  - `WAIT`: the access is stalled. `DataAck` goes to `IDLE`. With the watchdog in, `WaitCnt == TIMEOUT-1` also goes to `IDLE` with `abort`.
- `WaitCnt` is 5 bits. It clears on entry to `WAIT` and increments in `WAIT`. Width is `$clog2(TIMEOUT)+1`, saturating.
- A store never updates `ReadDataW`.
- Non-memory ops pass through M with no stall.
- No flush input: instructions reaching M are committed.

## Timing
- Reset values: all M/W fields 0, `DataReq` 0, `StallM` 0, state `IDLE`, `WaitCnt` 0, `MemFault` 0.
- Reset is asynchronous. Asserting it mid-`WAIT` drops `DataReq` immediately, and the access is abandoned.
- Latency E→W: 2 edges for non-memory ops and for zero-wait accesses (ack in the first request cycle).
- Latency E→W for an ack after N wait cycles: N+2 edges. `StallM` is high for exactly N cycles.
- Handshake: `DataReq`, `DataAdr`, `DataWe` and `DataWdata` stay stable while `DataReq=1 & DataAck=0`.
- One transfer per cycle in which `DataReq & DataAck`.
- `DataAck` while `DataReq=0` is ignored.
- Back-to-back memory ops: after the completing edge the next op's `DataReq` rises in the following cycle, with no idle gap.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - `WaitCnt` and the watchdog are built.
  - When `WAIT` lasts `TIMEOUT` cycles, `abort` pulses for 1 cycle and `StallM` is forced 0.
  - The instruction retires to W with `RegWriteW=0`, and `MemFault` sets until reset.
- `MEM_TIMEOUT_EN` undefined: the stage waits indefinitely for `DataAck`, and `MemFault` is constant 0.

## Test plan
- Zero-wait load:
  - Stimulus: `MemtoRegE=1`, `RegWriteE=1`, `RdE=3`, `ALUResultE=0x100`, with `DataAck` high the same cycle as `DataReq` and `DataRdata=0xDEADBEEF`.
  - Response: `StallM` never asserts; 2 edges later `ReadDataW=0xDEADBEEF`, `RdW=3`, `RegWriteW=1`.
- Store with 3 wait cycles:
  - Stimulus: `MemWriteE=1`, address 0x40, data 0x12345678; `DataAck` asserted on the 4th request cycle.
  - Response: `DataReq`/`DataWe` steady for 4 cycles; `StallM=1` for 3; `RegWriteW=0`; `ReadDataW` unchanged.
- ALU op behind a stalled load:
  - Stimulus: an ALU op with `RdE=5`, `ALUResultE=7` is held at E while the load waits.
  - Response: the ALU op enters M only on the ack edge; W shows a bubble during the stall, then the load, then the ALU op with `ALUOutW=7`.
- Reset mid-`WAIT`:
  - Stimulus: drive `reset` low during cycle 2 of a pending load.
  - Response: `DataReq`, `StallM`, `RegWriteM` and `RegWriteW` go 0 asynchronously; state is `IDLE` after release.
- Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT=4`):
  - Stimulus: a load with `DataAck` held at 0.
  - Response: `StallM` is high for 4 cycles then drops; `RegWriteW=0`; `MemFault=1` and stays 1 after later good accesses.
- Back-to-back loads:
  - Stimulus: two consecutive loads, both zero-wait, at addresses 0x0 and 0x4.
  - Response: `DataReq` high for 2 consecutive cycles with `DataAdr` 0x0 then 0x4; the W loads appear on successive cycles.
